// File: rtl/row_window_feeder.sv
// row_window_feeder: raster pixel stream to sliding three-row window for the border detector
module row_window_feeder #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      pix_valid,
  input  logic [7:0]                pix_in,
  output logic                      pix_ready,
  output logic [0:WIDTH-1][7:0]     row_top,
  output logic [0:WIDTH-1][7:0]     row_mid,
  output logic [0:WIDTH-1][7:0]     row_bot,
  output logic                      window_valid,
  output logic [$clog2(HEIGHT)-1:0] center_row,
  output logic                      frame_done
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;
  state_t state, state_nx;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [0:WIDTH-1][7:0] asm_buf, asm_row;
  logic take, row_end, last_row;
  assign take     = pix_valid && pix_ready;
  assign row_end  = take && x == XW'(WIDTH - 1);
  assign last_row = y == YW'(HEIGHT - 1);
  // the completed row includes the pixel arriving on the completing edge
  always_comb begin
    asm_row          = asm_buf;
    asm_row[WIDTH-1] = pix_in;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end
  // next state and handshake outputs
  always_comb begin
    pix_ready  = state == FILL || state == STREAM;
    frame_done = state == DONE;
    state_nx   = state == IDLE        ? (start ? FILL : IDLE) :
                 state == DONE        ? IDLE :
                 row_end && last_row  ? DONE :
                 row_end && y == YW'(2) ? STREAM : state;
  end
  // pixel assembly, counters and row shifting
  always_ff @(posedge clk) begin
    if (reset) begin
      x            <= '0;
      y            <= '0;
      asm_buf      <= '0;
      row_top      <= '0;
      row_mid      <= '0;
      row_bot      <= '0;
      window_valid <= 1'b0;
      center_row   <= '0;
    end else begin
      window_valid <= 1'b0;
      if (state == IDLE && start) begin
        x <= '0;
        y <= '0;
      end
      if (take) begin
        asm_buf[x] <= pix_in;
        x          <= row_end ? '0 : x + 1'b1;
        if (row_end) begin
          y       <= last_row ? '0 : y + 1'b1;
          row_top <= row_mid;
          row_mid <= row_bot;
          row_bot <= asm_row;
          if (y >= YW'(2)) begin
            window_valid <= 1'b1;
            center_row   <= y - 1'b1;
          end
        end
      end
    end
  end
endmodule
